// File: rtl/mips_core_pkg.sv
// Shared MIPS core types for the register rollback path.
// DATA_WIDTH is the core-wide data width; override it with +define+DATA_WIDTH=<n>.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = `DATA_WIDTH;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RESTORE,
    DONE
  } rb_state_e;

endpackage

// File: rtl/regfile_rollback_dirty_pick.sv
// Combinational picker: lowest and second-lowest set bits of a register mask.
module dirty_pick
  import mips_core_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  output reg_addr_t           idx0,
  output logic                vld0,
  output reg_addr_t           idx1,
  output logic                vld1
);

  logic [NUM_REGS-1:0] rest;

  function automatic reg_addr_t lowest(input logic [NUM_REGS-1:0] m);
    reg_addr_t r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i]) r = reg_addr_t'(i);
    return r;
  endfunction

  always_comb begin
    vld0 = |mask;
    idx0 = lowest(mask);
    rest = mask & ~(NUM_REGS'(vld0) << idx0);
    vld1 = |rest;
    idx1 = lowest(rest);
  end

endmodule

// File: rtl/regfile_rollback.sv
// Rollback sequencer: writes checkpointed registers back after a mispredict.
// ROLLBACK_DIRTY_ONLY_EN: restore only registers written since the checkpoint; else r1..r31.
module regfile_rollback
  import mips_core_pkg::*;
#(
  parameter int WR_PORTS = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            take_snapshot,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] snapshot_in,
  input  logic                            branch_resolved,
  input  logic                            mispredict,
  input  logic                            wb_en,
  input  reg_addr_t                       wb_addr,
  output logic [WR_PORTS-1:0]             rb_wr_en,
  output reg_addr_t [WR_PORTS-1:0]        rb_wr_addr,
  output logic [WR_PORTS-1:0][DATA_W-1:0] rb_wr_data,
  output logic                            rb_busy,
  output logic                            rb_done
);

  rb_state_e                state;
  logic [NUM_REGS-1:0]      mask;
  logic [NUM_REGS-1:0]      mask_src;
  logic [NUM_REGS-1:0]      issued;
  logic [NUM_REGS-1:0]      mask_left;
  logic                     issue_go;
  reg_addr_t                idx0, idx1;
  logic                     vld0, vld1;
  logic [WR_PORTS-1:0]      en_nxt;
  reg_addr_t [WR_PORTS-1:0] addr_nxt;
  logic                     unused_pick;

`ifdef ROLLBACK_DIRTY_ONLY_EN
  logic [NUM_REGS-1:0] wb_bit;
  assign wb_bit = (wb_en && wb_addr != '0) ? (NUM_REGS'(1) << wb_addr) : '0;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr};
`endif

  // A mispredict issues the first lanes on the same edge it is sampled.
  assign issue_go    = (state == ARMED && mispredict) || state == RESTORE;
  assign unused_pick = ^{idx1, vld1};

  always_comb begin
    mask_src = mask;
    if (state == ARMED) begin
`ifdef ROLLBACK_DIRTY_ONLY_EN
      mask_src = mask | wb_bit;
`else
      mask_src = {{(NUM_REGS-1){1'b1}}, 1'b0};
`endif
    end
  end

  dirty_pick u_pick (
    .mask (mask_src),
    .idx0 (idx0),
    .vld0 (vld0),
    .idx1 (idx1),
    .vld1 (vld1)
  );

  always_comb begin
    en_nxt   = '0;
    addr_nxt = '0;
    issued   = '0;
    for (int l = 0; l < WR_PORTS; l++) begin
      en_nxt[l]   = (l == 0) ? vld0 : vld1;
      addr_nxt[l] = (l == 0) ? idx0 : idx1;
      if (en_nxt[l]) issued[addr_nxt[l]] = 1'b1;
    end
    mask_left = mask_src & ~issued;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      rb_wr_en   <= '0;
      rb_wr_addr <= '0;
      rb_busy    <= 1'b0;
      rb_done    <= 1'b0;
    end else begin
      rb_wr_en   <= '0;
      rb_wr_addr <= '0;
      rb_busy    <= 1'b0;
      rb_done    <= 1'b0;
      if (issue_go) begin
        rb_busy <= 1'b1;
        if (mask_src == '0) begin
          state   <= DONE;
          mask    <= '0;
          rb_done <= 1'b1;
        end else begin
          state      <= RESTORE;
          mask       <= mask_left;
          rb_wr_en   <= en_nxt;
          rb_wr_addr <= addr_nxt;
        end
      end else begin
        case (state)
          IDLE: begin
            if (take_snapshot) begin
              mask  <= '0;
              state <= ARMED;
            end
          end
          ARMED: begin
            if (take_snapshot) begin
              mask <= '0;
            end else begin
`ifdef ROLLBACK_DIRTY_ONLY_EN
              mask <= mask | wb_bit;
`endif
              if (branch_resolved) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rb_wr_data = '0;
    for (int l = 0; l < WR_PORTS; l++)
      rb_wr_data[l] = snapshot_in[rb_wr_addr[l]];
  end

endmodule
